iic_cfg_sequencer: RTL



---
 rtl/iic_cfg_pkg.sv | 36 +++
 rtl/iic_cfg_rom.sv | 32 +++
 rtl/iic_cfg_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/iic_cfg_pkg.sv
// Shared definitions for the IIC power-up configuration sequencer:
// FSM encoding, table terminator and entry field layout.
package iic_cfg_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP = 4'd0,
        ST_FETCH = 4'd1,
        ST_LATCH = 4'd2,
        ST_WRITE = 4'd3,
        ST_GAP_W = 4'd4,
        ST_READ  = 4'd5,
        ST_CHECK = 4'd6,
        ST_GAP_N = 4'd7,
        ST_DONE  = 4'd8
    } cfg_state_t;

    localparam logic [7:0] TERM_SLAVE = 8'hFF;

    // Entry layout: {slave[7:0], reg[7:0], data[7:0]}
    localparam int SLAVE_LSB = 16;
    localparam int REG_LSB   = 8;
    localparam int DATA_LSB  = 0;

    function automatic logic [7:0] entry_slave(input logic [23:0] e);
        return e[SLAVE_LSB +: 8];
    endfunction

    function automatic logic [7:0] entry_reg(input logic [23:0] e);
        return e[REG_LSB +: 8];
    endfunction

    function automatic logic [7:0] entry_data(input logic [23:0] e);
        return e[DATA_LSB +: 8];
    endfunction

endpackage

// File: rtl/iic_cfg_rom.sv
// Configuration table ROM: case-based contents, one-cycle read latency.
// Addresses at or beyond DEPTH read back as the terminator entry.
module iic_cfg_rom
    import iic_cfg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [7:0]  rom_addr,
    output logic [23:0] rom_data
);

    // Registered table lookup
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rom_data <= 24'h000000;
        end else if (32'(rom_addr) >= DEPTH) begin
            rom_data <= {TERM_SLAVE, 8'h00, 8'h00};
        end else begin
            case (rom_addr)
                8'd0:    rom_data <= {8'h42, 8'h12, 8'hA1};
                8'd1:    rom_data <= {8'h42, 8'h13, 8'hB2};
                8'd2:    rom_data <= {8'h42, 8'h14, 8'hC3};
                8'd3:    rom_data <= {8'h1A, 8'h00, 8'h01};
                8'd4:    rom_data <= {8'h1A, 8'h01, 8'h80};
                default: rom_data <= {TERM_SLAVE, 8'h00, 8'h00};
            endcase
        end
    end

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Walks the configuration table, writing each entry through the IIC driver,
// optionally reading it back, retrying on mismatch and reporting status.
module iic_cfg_sequencer
    import iic_cfg_pkg::*;
#(
    parameter int ENTRIES     = 16,
    parameter int POWERUP_DLY = 1_000_000,
    parameter int GAP_DLY     = 1000,
    parameter int VERIFY      = 1,
    parameter int MAX_RETRY   = 3
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic [15:0] iic_slave,
    output logic        iic_wr_req,
    output logic [7:0]  iic_wr_data,
    input  logic        iic_wr_done,
    output logic        iic_rd_req,
    input  logic        iic_rd_done,
    input  logic [7:0]  iic_rd_data,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_err,
    output logic [7:0]  err_cnt
);

    localparam int CNT_MAX = (POWERUP_DLY > GAP_DLY) ? POWERUP_DLY : GAP_DLY;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] PWR_LAST  = CW'(POWERUP_DLY - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_DLY - 1);
    localparam logic [7:0]    LAST_IDX  = 8'(ENTRIES - 1);
    localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRY);

    cfg_state_t      state;
    logic [CW-1:0]   cnt;
    logic [7:0]      idx;
    logic [7:0]      retry;
    logic [23:0]     entry;
    logic [7:0]      rd_capture;
    logic            gap_to_write;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= ST_PWRUP;
            cnt          <= '0;
            idx          <= 8'd0;
            retry        <= 8'd0;
            entry        <= 24'h000000;
            rd_capture   <= 8'd0;
            gap_to_write <= 1'b0;
            rom_addr     <= 8'd0;
            iic_slave    <= 16'h0000;
            iic_wr_req   <= 1'b0;
            iic_wr_data  <= 8'd0;
            iic_rd_req   <= 1'b0;
            init_busy    <= 1'b1;
            init_done    <= 1'b0;
            init_err     <= 1'b0;
            err_cnt      <= 8'd0;
        end else begin
            case (state)
                ST_PWRUP: begin
                    if (cnt == PWR_LAST) begin
                        cnt      <= '0;
                        rom_addr <= idx;
                        state    <= ST_FETCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    entry <= rom_data;
                    retry <= 8'd0;
                    gap_to_write <= 1'b0;
                    if (entry_slave(rom_data) == TERM_SLAVE) begin
                        state     <= ST_DONE;
                        init_done <= 1'b1;
                        init_busy <= 1'b0;
                    end else begin
                        iic_slave   <= {entry_reg(rom_data), entry_slave(rom_data)};
                        iic_wr_data <= entry_data(rom_data);
                        iic_wr_req  <= 1'b1;
                        state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (iic_wr_done) begin
                        iic_wr_req <= 1'b0;
                        state      <= ST_GAP_W;
                    end
                end
                // Shared gap: leads to a re-write after a retry, else to readback
                ST_GAP_W: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (gap_to_write) begin
                            gap_to_write <= 1'b0;
                            iic_wr_req   <= 1'b1;
                            state        <= ST_WRITE;
                        end else if (VERIFY != 0) begin
                            iic_rd_req <= 1'b1;
                            state      <= ST_READ;
                        end else begin
                            state <= ST_GAP_N;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_READ: begin
                    if (iic_rd_done) begin
                        iic_rd_req <= 1'b0;
                        rd_capture <= iic_rd_data;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (rd_capture == entry_data(entry)) begin
                        state <= ST_GAP_N;
                    end else if (retry < RETRY_MAX) begin
                        retry        <= retry + 8'd1;
                        gap_to_write <= 1'b1;
                        state        <= ST_GAP_W;
                    end else begin
                        init_err <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end else begin
                            err_cnt <= err_cnt;
                        end
                        state <= ST_GAP_N;
                    end
                end
                ST_GAP_N: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        idx <= idx + 8'd1;
                        if (idx == LAST_IDX) begin
                            state     <= ST_DONE;
                            init_done <= 1'b1;
                            init_busy <= 1'b0;
                        end else begin
                            rom_addr <= idx + 8'd1;
                            state    <= ST_FETCH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Re-run skips the power-up wait
                ST_DONE: begin
                    if (start) begin
                        idx       <= 8'd0;
                        rom_addr  <= 8'd0;
                        init_err  <= 1'b0;
                        err_cnt   <= 8'd0;
                        init_done <= 1'b0;
                        init_busy <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                default: begin
                    state      <= ST_PWRUP;
                    cnt        <= '0;
                    iic_wr_req <= 1'b0;
                    iic_rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
